// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy flags.
// Buffers assembled triangle records between vertex fetch and vertex calc.
module fifo #(
  parameter int DBITS = 8,
  parameter int SIZE  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             half_full,
  output logic             almost_empty,
  output logic [DBITS-1:0] dout
);

  localparam int DEPTH = 1 << SIZE;

  localparam logic [SIZE:0] CNT_FULL = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0] CNT_AF   = (SIZE+1)'(DEPTH - 1);
  localparam logic [SIZE:0] CNT_HF   = (SIZE+1)'(DEPTH / 2);
  localparam logic [SIZE:0] CNT_ONE  = (SIZE+1)'(1);
  localparam logic [SIZE:0] CNT_ZERO = '0;

  localparam logic [SIZE-1:0] PTR_ONE = SIZE'(1);

  logic [DBITS-1:0] mem_q [DEPTH];

  logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [SIZE:0]   count_q, count_d;

  logic do_wr;
  logic do_rd;

  assign empty        = (count_q == CNT_ZERO);
  assign full         = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= CNT_AF);
  assign half_full    = (count_q >= CNT_HF);
  assign almost_empty = (count_q <= CNT_ONE);

  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  assign dout = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo at DBITS=480, SIZE=4.
// Table vectors, directed corners and a random run against a queue model.
module tb_fifo;

  localparam int DB    = 480;
  localparam int SZ    = 4;
  localparam int DEPTH = 16;

  logic          clock;
  logic          reset;
  logic          wr;
  logic          rd;
  logic [DB-1:0] din;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          half_full;
  logic          almost_empty;
  logic [DB-1:0] dout;

  int checks;
  int failures;

  logic [DB-1:0] q[$];

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DB-1:0] din;
    int            exp_cnt;
    logic [DB-1:0] exp_dout;
  } vec_t;

  vec_t vecs[33];

  fifo #(.DBITS(DB), .SIZE(SZ)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .din         (din),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .half_full   (half_full),
    .almost_empty(almost_empty),
    .dout        (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [DB-1:0] act,
                     input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // flags packed as {empty, almost_empty, half_full, almost_full, full}
  task automatic chk_flags(input string name, input int c);
    logic [4:0] got;
    logic [4:0] exp;
    got = {empty, almost_empty, half_full, almost_full, full};
    exp = {c == 0, c <= 1, c >= DEPTH/2, c >= DEPTH-1, c == DEPTH};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s flags got=%b want=%b (count %0d)",
               name, got, exp, c);
    end
  endtask

  task automatic chk_model(input string name);
    chk_flags(name, q.size());
    if (q.size() > 0) chk({name, "_dout"}, dout, q[0]);
  endtask

  // Drive one cycle, then sample 1 time unit after the edge.
  task automatic apply(input logic w, input logic r, input logic [DB-1:0] d);
    bit dw;
    bit dr;
    wr  = w;
    rd  = r;
    din = d;
    dw  = w && (q.size() < DEPTH);
    dr  = r && (q.size() > 0);
    @(posedge clock);
    #1;
    if (dr) void'(q.pop_front());
    if (dw) q.push_back(d);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  function automatic logic [DB-1:0] rnd_word();
    logic [DB-1:0] v;
    for (int i = 0; i < 15; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [DB-1:0] pat;
    logic [DB-1:0] w;
    checks   = 0;
    failures = 0;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk_flags("reset", 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_flags("idle", 0);

    // table: fill 16, blocked write, drain 16
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, DB'(i + 1), i + 1, DB'(1)};
    vecs[16] = '{1'b1, 1'b0, DB'(32'hDEAD), 16, DB'(1)};
    for (int k = 0; k < 16; k++)
      vecs[17 + k] = '{1'b0, 1'b1, '0, 15 - k, DB'(k + 2)};

    for (int i = 0; i < 33; i++) begin
      apply(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk_flags($sformatf("vec%0d", i), vecs[i].exp_cnt);
      if (vecs[i].exp_cnt > 0)
        chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // wide pattern, read in the following cycle
    for (int i = 0; i < 15; i++)
      pat[i*32 +: 32] = 32'hA0000000 + i * 32'h01010101 + 32'h1;
    apply(1'b1, 1'b0, pat);
    chk("pat_show", dout, pat);
    rd = 1'b1;
    #2;
    chk("pat_rdcycle", dout, pat);
    apply(1'b0, 1'b1, '0);
    chk_flags("pat_after", 0);

    // reset mid-fill at count 5
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, DB'(100 + i));
    chk_model("pre_rst");
    reset = 1'b0;
    #1;
    chk_flags("async_rst", 0);
    q.delete();
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_flags("post_rst", 0);

    // wrap-around: 10/10 then 12/12
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, rnd_word());
      chk_model("wrap_f10");
    end
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, '0);
      chk_model("wrap_d10");
    end
    for (int i = 0; i < 12; i++) begin
      apply(1'b1, 1'b0, rnd_word());
      chk_model("wrap_f12");
    end
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b1, '0);
      chk_model("wrap_d12");
    end

    // simultaneous wr/rd at count 3
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, DB'(200 + i));
    apply(1'b1, 1'b1, DB'(203));
    chk_flags("sim3", 3);
    chk("sim3_dout", dout, DB'(201));
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, '0);
      chk_model("sim3_drain");
    end

    // simultaneous wr/rd when empty
    w = rnd_word();
    apply(1'b1, 1'b1, w);
    chk_flags("sim0", 1);
    chk("sim0_dout", dout, w);
    apply(1'b0, 1'b1, '0);
    chk_flags("sim0_drain", 0);

    // simultaneous wr/rd when full
    for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, DB'(300 + i));
    chk_flags("sim16_fill", 16);
    apply(1'b1, 1'b1, DB'(32'hBAD));
    chk_flags("sim16", 15);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("sim16_d%0d", i), dout, DB'(301 + i));
      apply(1'b0, 1'b1, '0);
    end
    chk_flags("sim16_empty", 0);
    q.delete();

    // read on empty, then write-then-read
    apply(1'b0, 1'b1, '0);
    chk_flags("rd_empty", 0);
    w = rnd_word();
    apply(1'b1, 1'b0, w);
    chk("wr_after_ue", dout, w);
    apply(1'b0, 1'b1, '0);
    chk_flags("rd_after_ue", 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
            rnd_word());
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
